mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single main data memory between the instruction cache and the data cache. It sits between the cache controllers' miss interfaces and the memory's block interface. It serialises block reads and writebacks, latches the winning request, runs the memory busywait handshake, and returns the fetched block to the correct cache. Requesters see an ordinary memory: busywait stays high until their transfer has completed.

## Interface
- ADDR_W, 6: block address width (tag+index)
- DATA_W, 128: block width in bits
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- i_read  in  1  icache block read request
- i_address  in  ADDR_W  icache block address
- i_readdata  out  DATA_W  block returned to icache
- i_busywait  out  1  icache stall
- d_read  in  1  dcache block read request
- d_write  in  1  dcache block writeback request
- d_address  in  ADDR_W  dcache block address
- d_writedata  in  DATA_W  dcache writeback data
- d_readdata  out  DATA_W  block returned to dcache
- d_busywait  out  1  dcache stall
- mem_read, mem_write  out  1 each  memory strobes
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  DATA_W  memory write data
- mem_readdata  in  DATA_W  memory read data
- mem_busywait  in  1  memory busy

## Operation
- Requests: i_req = i_read; d_req = d_read | d_write.
- Asserting d_read and d_write together is illegal. d_write wins, and a sim-only error is printed.
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE: at a posedge with no request, stay.
  - Only one requester: grant it.
  - Both requesting: arbitration rule applies (see Configuration).
- On grant, latch owner, address, op and (dcache write) writedata into registers.
- Memory outputs are driven only from these latched registers, never directly from requester ports.
- GRANT_x: mem_read or mem_write is high per the latched op, with mem_address and mem_writedata from the latches.
  - The entry edge is ignored for completion.
  - Completion is the first later posedge that samples mem_busywait=0. At that edge, go to DONE.
  - On a read, capture mem_readdata into the owner's readdata register.
- DONE: lasts exactly 1 cycle. mem_read and mem_write are 0. Then go to IDLE unconditionally.
- Busywait outputs are combinational:
  - i_busywait = i_req & !(state==DONE & owner==I).
  - d_busywait is the same expression using d_req and owner==D.
- A requester that drops its request mid-grant does not abort the transfer. The transfer completes and read data is still captured.
- i_readdata and d_readdata hold their value until the next completed read for that port.
- mem_address and mem_writedata are 0 in IDLE and DONE.

## Timing
- Reset values (at the first posedge with reset=1), for mem_read, mem_write, mem_address, mem_writedata, i_readdata and d_readdata: all 0.
- Reset values (same edge) for internal state: state=IDLE, owner=I, last_grant=D.
- Busywait outputs follow their equations, so they are high if the request is high.
- Reset mid-transfer abandons the transfer. Strobes are 0 after that edge and the captured data is cleared.
- Grant latency: a request high before posedge k gives GRANT_x from k. Memory strobes are valid after k.
- Memory completing at posedge m gives:
  - DONE during cycle m..m+1;
  - requester busywait low in that cycle;
  - readdata valid from m.
- Back-to-back: IDLE spans m+1..m+2, and the next grant is at the earliest at m+2. Minimum cost is 2 arbitration cycles per transfer plus memory latency.
- While in GRANT or DONE, new requests and changes on requester address/data lines are ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On a tie, grant the port that is not last_grant. last_grant updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority. The dcache always wins ties and last_grant is unused.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset check: hold reset 2 cycles with i_read=1 → mem_read=0, mem_write=0, i_readdata=0, i_busywait=1, state IDLE.
- Lone icache read: i_read=1, i_address=6'h15, memory model with 5-cycle busywait returning 128'hA5…A5 → mem_read high with mem_address 6'h15 from edge k. i_busywait low for exactly 1 cycle after completion, i_readdata=128'hA5…A5.
- Dcache writeback: d_write=1, d_address=6'h3C, d_writedata=128'h1234 → mem_write=1 with the same address/data, mem_read=0, d_readdata unchanged.
- Tie, fixed priority: i_read and d_read both rise before the same edge, three times → dcache granted each time, icache served only after the dcache drops its request.
- Tie, MEM_ARB_RR_EN: same stimulus → grants alternate D, I, D. Each requester's busywait clears only in its own DONE cycle.
- Reset mid-transfer: assert reset 2 cycles into GRANT_I → strobes 0 after that edge. A later i_read re-issues mem_read with the same address.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single block-interface main memory between icache and dcache.
// Build macro MEM_ARB_RR_EN selects round-robin tie-break; undefined gives fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic i_req;
    logic d_req;
    logic grant;
    logic grant_d;
    logic in_grant;
    logic complete;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;
`endif

    // Decide which port wins if a grant happens this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_d = 1'b0;
        if (d_req && !i_req) begin
            grant_d = 1'b1;
        end else if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
            grant_d = (last_grant == OWN_I);
`else
            grant_d = 1'b1;
`endif
        end
    end

    assign grant    = (state == IDLE) && (i_req || d_req);
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);
    // Entry edge never completes: completion is only checked once already in a GRANT state.
    assign complete = in_grant && !mem_busywait;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nx = grant_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!mem_busywait) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            owner   <= OWN_I;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            // NOTE: returned-block registers are reset too, so an abandoned transfer leaves no stale data.
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= grant_d ? OWN_D : OWN_I;
                addr_q  <= grant_d ? d_address : i_address;
                // A simultaneous d_read/d_write is treated as a writeback.
                write_q <= grant_d && d_write;
                wdata_q <= (grant_d && d_write) ? d_writedata : '0;
            end
            if (complete && !write_q) begin
                if (owner == OWN_D) begin
                    d_rdata_q <= mem_readdata;
                end else begin
                    i_rdata_q <= mem_readdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= OWN_D;
        end else if (grant) begin
            last_grant <= grant_d ? OWN_D : OWN_I;
        end
    end
`endif

    // Memory side sees only latched request state, and nothing outside GRANT.
    assign mem_read      = in_grant && !write_q;
    assign mem_write     = in_grant && write_q;
    assign mem_address   = in_grant ? addr_q  : '0;
    assign mem_writedata = in_grant ? wdata_q : '0;

    assign i_readdata = i_rdata_q;
    assign d_readdata = d_rdata_q;

    assign i_busywait = i_req && !((state == DONE) && (owner == OWN_I));
    assign d_busywait = d_req && !((state == DONE) && (owner == OWN_D));

    illegal_dcache_rw: assert property (@(posedge clock) disable iff (reset) !(d_read && d_write))
        else $error("mem_arbiter: d_read and d_write asserted together; writeback takes precedence");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency block memory model.
// Define MEM_ARB_RR_EN for both bench and RTL to exercise the round-robin build.
module tb_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 128;
    localparam int LAT    = 5;
    localparam int XFER   = LAT + 1;

    typedef logic [DATA_W-1:0] word_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    // Memory model: busy as soon as a strobe appears, ready after LAT strobed edges.
    int    mem_cnt;
    word_t mem_data;

    always @(posedge clock) begin
        if (reset || !(mem_read || mem_write)) begin
            mem_cnt <= 0;
        end else if (mem_cnt < LAT) begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt < LAT);
    assign mem_readdata = mem_data;

    int    n_cmp;
    int    n_bad;
    word_t i_exp;
    word_t d_exp;
    word_t pat;
    logic [2:0] tie_exp;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Waits (bounded) for the selected port's busywait to drop, then checks the DONE cycle.
    task automatic wait_done(input logic is_d, input int exp_n, input string tag);
        int   n;
        logic bw;
        n  = 0;
        bw = is_d ? d_busywait : i_busywait;
        while (bw && n < 40) begin
            tick();
            n++;
            bw = is_d ? d_busywait : i_busywait;
        end
        check({tag, "_cycles"}, word_t'(n), word_t'(exp_n));
        check({tag, "_done_rd"}, word_t'(mem_read), '0);
        check({tag, "_done_wr"}, word_t'(mem_write), '0);
        check({tag, "_done_addr"}, word_t'(mem_address), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mem_data = '0;
        i_exp = '0;
        d_exp = '0;
`ifdef MEM_ARB_RR_EN
        tie_exp = 3'b101;
`else
        tie_exp = 3'b111;
`endif

        // Reset held two cycles with an icache request pending.
        reset = 1'b1;
        i_read = 1'b1;
        i_address = 6'h15;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = '0;
        d_writedata = '0;
        tick();
        tick();
        check("rst_mem_read", word_t'(mem_read), '0);
        check("rst_mem_write", word_t'(mem_write), '0);
        check("rst_mem_addr", word_t'(mem_address), '0);
        check("rst_mem_wdata", mem_writedata, '0);
        check("rst_i_rdata", i_readdata, '0);
        check("rst_d_rdata", d_readdata, '0);
        check("rst_i_busy", word_t'(i_busywait), word_t'(1'b1));
        check("rst_d_busy", word_t'(d_busywait), '0);
        reset = 1'b0;
        i_read = 1'b0;
        tick();

        // Dcache writeback; requester lines change mid-grant and must be ignored.
        d_write = 1'b1;
        d_address = 6'h3C;
        d_writedata = 128'h1234;
        tick();
        check("wb_mem_write", word_t'(mem_write), word_t'(1'b1));
        check("wb_mem_read", word_t'(mem_read), '0);
        check("wb_addr", word_t'(mem_address), word_t'(6'h3C));
        check("wb_wdata", mem_writedata, word_t'(128'h1234));
        check("wb_d_busy", word_t'(d_busywait), word_t'(1'b1));
        d_address = 6'h01;
        d_writedata = 128'hFFFF;
        tick();
        check("wb_addr_held", word_t'(mem_address), word_t'(6'h3C));
        check("wb_wdata_held", mem_writedata, word_t'(128'h1234));
        wait_done(1'b1, XFER - 1, "wb");
        check("wb_d_rdata", d_readdata, d_exp);
        check("wb_i_rdata", i_readdata, i_exp);
        d_write = 1'b0;
        tick();
        check("wb_idle_wr", word_t'(mem_write), '0);

        // Lone icache read against a 5-cycle memory.
        mem_data = {16{8'hA5}};
        i_read = 1'b1;
        i_address = 6'h15;
        tick();
        check("ir_mem_read", word_t'(mem_read), word_t'(1'b1));
        check("ir_mem_write", word_t'(mem_write), '0);
        check("ir_addr", word_t'(mem_address), word_t'(6'h15));
        check("ir_i_busy", word_t'(i_busywait), word_t'(1'b1));
        wait_done(1'b0, XFER, "ir");
        i_exp = {16{8'hA5}};
        check("ir_i_rdata", i_readdata, i_exp);
        check("ir_d_rdata", d_readdata, d_exp);
        tick();
        check("ir_busy_again", word_t'(i_busywait), word_t'(1'b1));
        check("ir_idle_rd", word_t'(mem_read), '0);
        i_read = 1'b0;
        tick();

        // Three ties with both ports requesting continuously.
        i_read = 1'b1;
        d_read = 1'b1;
        i_address = 6'h15;
        d_address = 6'h3C;
        for (int it = 0; it < 3; it++) begin
            pat = {16{8'h30 + it[7:0]}};
            mem_data = pat;
            tick();
            check("tie_addr", word_t'(mem_address), tie_exp[it] ? word_t'(6'h3C) : word_t'(6'h15));
            check("tie_rd", word_t'(mem_read), word_t'(1'b1));
            wait_done(tie_exp[it], XFER, "tie");
            if (tie_exp[it]) begin
                check("tie_other_busy_i", word_t'(i_busywait), word_t'(1'b1));
                d_exp = pat;
            end else begin
                check("tie_other_busy_d", word_t'(d_busywait), word_t'(1'b1));
                i_exp = pat;
            end
            check("tie_i_rdata", i_readdata, i_exp);
            check("tie_d_rdata", d_readdata, d_exp);
            if (it == 2) begin
                d_read = 1'b0;
            end
            tick();
        end

        // Icache served once the dcache has dropped out.
        mem_data = {16{8'h5A}};
        tick();
        check("post_tie_addr", word_t'(mem_address), word_t'(6'h15));
        check("post_tie_rd", word_t'(mem_read), word_t'(1'b1));
        check("post_tie_d_busy", word_t'(d_busywait), '0);
        wait_done(1'b0, XFER, "post_tie");
        i_exp = {16{8'h5A}};
        check("post_tie_i_rdata", i_readdata, i_exp);
        check("post_tie_d_rdata", d_readdata, d_exp);
        i_read = 1'b0;
        tick();

        // Reset two cycles into GRANT_I, then the same request is re-issued.
        mem_data = {16{8'hC3}};
        i_read = 1'b1;
        i_address = 6'h15;
        tick();
        check("mrst_rd_before", word_t'(mem_read), word_t'(1'b1));
        tick();
        reset = 1'b1;
        tick();
        check("mrst_rd", word_t'(mem_read), '0);
        check("mrst_wr", word_t'(mem_write), '0);
        check("mrst_addr", word_t'(mem_address), '0);
        check("mrst_i_rdata", i_readdata, '0);
        check("mrst_d_rdata", d_readdata, '0);
        check("mrst_i_busy", word_t'(i_busywait), word_t'(1'b1));
        tick();
        reset = 1'b0;
        tick();
        check("mrst_regrant_rd", word_t'(mem_read), word_t'(1'b1));
        check("mrst_regrant_addr", word_t'(mem_address), word_t'(6'h15));
        wait_done(1'b0, XFER, "mrst");
        check("mrst_i_rdata_new", i_readdata, word_t'({16{8'hC3}}));
        i_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
